// File: rtl/dispatch_buffer.sv
// Dual-lane in-order FIFO between decode and the issue queue; pushes up to two per cycle bounded by queue free space.
// Optional same-cycle bypass from decode to issue is compiled in with `define DISPATCH_BYPASS_EN.
module dispatch_buffer #(
  parameter int DEPTH   = 4,
  parameter int CNT_W   = $clog2(DEPTH) + 1,
  parameter int ELEM_W  = 32,
  parameter int IQ_ADDR = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [1:0]             dec_valid,
  input  logic [1:0][ELEM_W-1:0] dec_data,
  output logic                   dec_ready,
  input  logic [IQ_ADDR-1:0]     iq_size_left,
  output logic [1:0][ELEM_W-1:0] iq_in_data,
  output logic [1:0]             iq_in_data_number,
  output logic [CNT_W-1:0]       count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [ELEM_W-1:0]       buf_r [DEPTH];
  logic [PTR_W-1:0]        head_r;
  logic [PTR_W-1:0]        tail_r;
  logic [CNT_W-1:0]        count_r;

  logic                    ready_s;
  logic [1:0]              n_in_s;
  logic [1:0]              lim_s;
  logic [CNT_W-1:0]        avail_s;
  logic [1:0]              n_out_s;
  logic [1:0]              n_buf_s;
  logic [1:0]              n_byp_s;
  logic [1:0]              n_wr_s;
  logic [ELEM_W-1:0]       wr_data0_s;
  logic [1:0][ELEM_W-1:0]  iq_data_s;

  // Accept side: ready only from registered occupancy, so a 2-wide write never overflows.
  always_comb begin
    ready_s = rst & ~flush & (count_r <= CNT_W'(DEPTH - 2));
    n_in_s  = 2'd0;
    if (ready_s) begin
      case (dec_valid)
        2'b11:   n_in_s = 2'd2;
        2'b01:   n_in_s = 2'd1;
        default: n_in_s = 2'd0;
      endcase
    end else begin
      n_in_s = 2'd0;
    end
  end

  // Issue side: push count, split between buffered and bypassed instructions.
  always_comb begin
    lim_s   = 2'd0;
    avail_s = {CNT_W{1'b0}};
    n_out_s = 2'd0;
    n_buf_s = 2'd0;
    if (iq_size_left >= IQ_ADDR'(2)) begin
      lim_s = 2'd2;
    end else begin
      lim_s = iq_size_left[1:0];
    end
`ifdef DISPATCH_BYPASS_EN
    avail_s = count_r + CNT_W'(n_in_s);
`else
    avail_s = count_r;
`endif
    if (!rst || flush) begin
      n_out_s = 2'd0;
    end else if (avail_s >= CNT_W'(lim_s)) begin
      n_out_s = lim_s;
    end else begin
      n_out_s = avail_s[1:0];
    end
    // Older buffered entries always go first; only the remainder is taken from decode.
    if (count_r >= CNT_W'(n_out_s)) begin
      n_buf_s = n_out_s;
    end else begin
      n_buf_s = count_r[1:0];
    end
    n_byp_s = n_out_s - n_buf_s;
    n_wr_s  = n_in_s - n_byp_s;
  end

  // Issue lane data: buffer head first, then accepted decode lanes, zero beyond n_out.
  always_comb begin
    iq_data_s = {2*ELEM_W{1'b0}};
    if (n_buf_s != 2'd0) begin
      iq_data_s[0] = buf_r[head_r];
    end else begin
      iq_data_s[0] = dec_data[0];
    end
    if (n_buf_s == 2'd2) begin
      iq_data_s[1] = buf_r[head_r + PTR_W'(1)];
    end else if (n_buf_s == 2'd1) begin
      iq_data_s[1] = dec_data[0];
    end else begin
      iq_data_s[1] = dec_data[1];
    end
    if (n_out_s < 2'd1) begin
      iq_data_s[0] = {ELEM_W{1'b0}};
    end else begin
      iq_data_s[0] = iq_data_s[0];
    end
    if (n_out_s < 2'd2) begin
      iq_data_s[1] = {ELEM_W{1'b0}};
    end else begin
      iq_data_s[1] = iq_data_s[1];
    end
  end

  // First non-bypassed accepted lane.
  always_comb begin
    if (n_byp_s == 2'd0) begin
      wr_data0_s = dec_data[0];
    end else begin
      wr_data0_s = dec_data[1];
    end
  end

  // Pointer and occupancy state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_r  <= {PTR_W{1'b0}};
      tail_r  <= {PTR_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
    end else if (flush) begin
      head_r  <= {PTR_W{1'b0}};
      tail_r  <= {PTR_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
    end else begin
      head_r  <= head_r + PTR_W'(n_buf_s);
      tail_r  <= tail_r + PTR_W'(n_wr_s);
      count_r <= count_r + CNT_W'(n_in_s) - CNT_W'(n_out_s);
    end
  end

  // Buffer storage; a two-entry write only happens when nothing was bypassed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        buf_r[i] <= {ELEM_W{1'b0}};
      end
    end else begin
      if (n_wr_s != 2'd0) begin
        buf_r[tail_r] <= wr_data0_s;
      end
      if (n_wr_s == 2'd2) begin
        buf_r[tail_r + PTR_W'(1)] <= dec_data[1];
      end
    end
  end

  assign dec_ready         = ready_s;
  assign iq_in_data        = iq_data_s;
  assign iq_in_data_number = n_out_s;
  assign count             = count_r;

endmodule
